// File: rtl/mem_bus_pkg.sv
// Shared memory-map constants, FSM state encoding and fixed-byte decode for mem_bus.
package mem_bus_pkg;

  localparam logic [15:0] VEC_NMI_LSB     = 16'hFFFA;
  localparam logic [15:0] VEC_NMI_MSB     = 16'hFFFB;
  localparam logic [15:0] VEC_RST_LSB     = 16'hFFFC;
  localparam logic [15:0] VEC_RST_MSB     = 16'hFFFD;
  localparam logic [15:0] VEC_IRQ_LSB     = 16'hFFFE;
  localparam logic [15:0] VEC_IRQ_MSB     = 16'hFFFF;
  localparam logic [15:0] DEFAULT_IO_ADDR = 16'hBF00;

  // One-hot to match the core's state style.
  typedef enum logic [1:0] {
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  typedef enum logic {
    SEL_BYTE = 1'b0,
    SEL_RAM  = 1'b1
  } rd_sel_e;

  // Read value for every address that is neither RAM nor the I/O register.
  function automatic logic [7:0] fixed_byte(input logic [15:0] addr,
                                            input logic [15:0] rst_vec);
    case (addr)
      VEC_RST_LSB: fixed_byte = rst_vec[7:0];
      VEC_RST_MSB: fixed_byte = rst_vec[15:8];
      VEC_NMI_LSB, VEC_NMI_MSB,
      VEC_IRQ_LSB, VEC_IRQ_MSB: fixed_byte = 8'h00;
      default:     fixed_byte = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Core memory port plus boot-image byte stream, grouped for mem_bus.
interface mem_bus_if;
  logic [15:0] address;
  logic [7:0]  wr_data;
  logic        wr_enable;
  logic [7:0]  rd_data;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_last;
  logic        load_ready;

  modport slave (
    input  address, wr_data, wr_enable, load_data, load_valid, load_last,
    output rd_data, load_ready
  );

  modport master (
    output address, wr_data, wr_enable, load_data, load_valid, load_last,
    input  rd_data, load_ready
  );
endinterface

// File: rtl/mem_bus_ram_sp.sv
// Single-port byte-wide synchronous RAM; a write returns the old byte on the same cycle.
module ram_sp #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  logic [7:0] mem_q [2**ADDR_WIDTH];
  logic [7:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; contents persist across resetn.
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[addr];
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_bus.sv
// Boot loader + address decoder in front of the core: streams an image into RAM, then serves the core bus.
module mem_bus
  import mem_bus_pkg::*;
#(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [15:0] RESET_VEC  = 16'h0200,
  parameter logic [15:0] IO_ADDR    = DEFAULT_IO_ADDR
) (
  input  logic             clk,
  input  logic             resetn,
  mem_bus_if.slave         bus,
  input  logic [7:0]       io_in,
  output logic             load_err,
  output logic             proc_resetn,
  output logic [7:0]       io_out,
  output logic             io_strobe
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic                    load_err_q, load_err_d;
  logic                    proc_resetn_q, proc_resetn_d;
  rd_sel_e                 sel_q, sel_d;
  logic [7:0]              byte_q, byte_d;
  logic [7:0]              io_out_q, io_out_d;
  logic                    io_strobe_q, io_strobe_d;

  logic                    handshake, last_slot, in_ram;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic                    ram_we;
  logic [7:0]              ram_wdata, ram_rdata;

  assign handshake = (state_q == ST_LOAD) && bus.load_valid;
  assign last_slot = (ptr_q == {ADDR_WIDTH{1'b1}});
  assign in_ram    = ((bus.address >> ADDR_WIDTH) == 16'h0000);

  // NOTE: every output of this block is given a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    load_err_d  = load_err_q;
    sel_d       = SEL_BYTE;
    byte_d      = 8'h00;
    io_out_d    = io_out_q;
    io_strobe_d = 1'b0;
    ram_addr    = ptr_q;
    ram_we      = 1'b0;
    ram_wdata   = bus.load_data;

    case (state_q)
      ST_LOAD: begin
        if (handshake) begin
          ram_we = 1'b1;
          // The last RAM slot ends the load even without load_last; the pointer never wraps.
          if (bus.load_last || last_slot) begin
            state_d    = ST_RUN;
            load_err_d = !bus.load_last;
          end else begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      ST_RUN: begin
        ram_addr  = bus.address[ADDR_WIDTH-1:0];
        ram_wdata = bus.wr_data;
        if (in_ram) begin
          sel_d  = SEL_RAM;
          ram_we = bus.wr_enable;
        end else if (bus.address == IO_ADDR) begin
          byte_d = io_in;
          if (bus.wr_enable) begin
            io_out_d    = bus.wr_data;
            io_strobe_d = 1'b1;
          end
        end else begin
          byte_d = fixed_byte(bus.address, RESET_VEC);
        end
      end
      default: state_d = ST_LOAD;
    endcase

    proc_resetn_d = (state_d == ST_RUN);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_LOAD;
      ptr_q         <= '0;
      load_err_q    <= 1'b0;
      proc_resetn_q <= 1'b0;
      sel_q         <= SEL_BYTE;
      byte_q        <= 8'h00;
      io_out_q      <= 8'h00;
      io_strobe_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      load_err_q    <= load_err_d;
      proc_resetn_q <= proc_resetn_d;
      sel_q         <= sel_d;
      byte_q        <= byte_d;
      io_out_q      <= io_out_d;
      io_strobe_q   <= io_strobe_d;
    end
  end

  ram_sp #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM output is already registered; the select was registered alongside it.
  assign bus.rd_data    = (sel_q == SEL_RAM) ? ram_rdata : byte_q;
  assign bus.load_ready = (state_q == ST_LOAD);
  assign load_err       = load_err_q;
  assign proc_resetn    = proc_resetn_q;
  assign io_out         = io_out_q;
  assign io_strobe      = io_strobe_q;

endmodule
